// File: rtl/regfile_access_ctrl_if.sv
// Command/response bundle between the system sequencer and regfile_access_ctrl.
// master = sequencer side, slave = controller side.
interface regfile_access_ctrl_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] rsp_addr;
    logic              err;
    logic              busy;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_addr, err, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_addr, err, busy
    );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Command-driven initiator for the regfile8x16 storage port: sequences single/burst
// writes and reads onto the regfile and returns tagged read responses.
module regfile_access_ctrl #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                CLK,
    input  logic                RST,
    regfile_access_ctrl_if.slave bus,
    output logic [DATA_W-1:0]   WrData,
    output logic [ADDR_W-1:0]   Address,
    output logic                WrEn,
    output logic                RdEn,
    input  logic [DATA_W-1:0]   RdData
);

    typedef enum logic [1:0] {StIdle, StWr, StRd, StDrain} state_e;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DepthW   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CntOne   = (ADDR_W + 1)'(1);

    state_e              state_q, state_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic                wr_en_q, wr_en_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                err_q, err_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                busy_q, busy_d;
    logic [RD_LAT-1:0]   tag_vld_q, tag_vld_d;
    logic [ADDR_W-1:0]   tag_addr_q [RD_LAT];
    logic [ADDR_W-1:0]   tag_addr_d [RD_LAT];
    logic                pending;

    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        return (a == LastAddr) ? '0 : a + 1'b1;
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        address_d   = address_q;
        wr_data_d   = wr_data_q;
        err_d       = 1'b0;
        cmd_ready_d = cmd_ready_q;
        busy_d      = busy_q;

        // Tag pipeline: stage 0 tracks the read issued this cycle, last stage is the response.
        tag_vld_d[0]  = rd_en_q;
        tag_addr_d[0] = address_q;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            tag_vld_d[i]  = tag_vld_q[i-1];
            tag_addr_d[i] = tag_addr_q[i-1];
        end
        pending = 1'b0;
        for (int i = 0; i < int'(RD_LAT) - 1; i++) begin
            pending = pending | tag_vld_q[i];
        end

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    if ({1'b0, bus.cmd_addr} >= DepthW) begin
                        err_d = 1'b1;
                    end else begin
                        address_d   = bus.cmd_addr;
                        cmd_ready_d = 1'b0;
                        busy_d      = 1'b1;
                        cnt_d       = bus.cmd_op[1] ? ({1'b0, bus.cmd_len} + 1'b1) : CntOne;
                        if (!bus.cmd_op[0]) begin
                            state_d   = StWr;
                            wr_en_d   = 1'b1;
                            wr_data_d = bus.cmd_data;
                        end else begin
                            state_d = StRd;
                            rd_en_d = 1'b1;
                        end
                    end
                end
            end
            StWr: begin
                if (cnt_q == CntOne) begin
                    state_d     = StIdle;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end else begin
                    wr_en_d   = 1'b1;
                    address_d = wrap_inc(address_q);
                    cnt_d     = cnt_q - 1'b1;
                end
            end
            StRd: begin
                if (cnt_q == CntOne) begin
                    state_d = StDrain;
                end else begin
                    rd_en_d   = 1'b1;
                    address_d = wrap_inc(address_q);
                    cnt_d     = cnt_q - 1'b1;
                end
            end
            StDrain: begin
                if (!pending) begin
                    state_d     = StIdle;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = StIdle;
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            address_q   <= '0;
            wr_data_q   <= '0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            tag_vld_q   <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                tag_addr_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            address_q   <= address_d;
            wr_data_q   <= wr_data_d;
            err_q       <= err_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            tag_vld_q   <= tag_vld_d;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                tag_addr_q[i] <= tag_addr_d[i];
            end
        end
    end

    assign WrData        = wr_data_q;
    assign Address       = address_q;
    assign WrEn          = wr_en_q;
    assign RdEn          = rd_en_q;
    assign bus.cmd_ready = cmd_ready_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
    assign bus.rsp_valid = tag_vld_q[RD_LAT-1];
    // Gated so response fields read as zero outside a response beat and after reset.
    assign bus.rsp_data  = tag_vld_q[RD_LAT-1] ? RdData : '0;
    assign bus.rsp_addr  = tag_vld_q[RD_LAT-1] ? tag_addr_q[RD_LAT-1] : '0;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a behavioural registered-read regfile.
module tb_regfile_access_ctrl;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 4;

    logic              CLK;
    logic              RST;
    logic [DATA_W-1:0] WrData;
    logic [ADDR_W-1:0] Address;
    logic              WrEn;
    logic              RdEn;
    logic [DATA_W-1:0] RdData;
    logic [DATA_W-1:0] mem [8];

    int vectors     = 0;
    int miscompares = 0;
    bit mon_en      = 0;

    regfile_access_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_access_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(8), .RD_LAT(1)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .bus     (bus),
        .WrData  (WrData),
        .Address (Address),
        .WrEn    (WrEn),
        .RdEn    (RdEn),
        .RdData  (RdData)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial RdData = '0;
    always @(posedge CLK) begin
        if (WrEn) mem[Address[2:0]] <= WrData;
        if (RdEn) RdData <= mem[Address[2:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            check("wr_rd_exclusive", 32'(WrEn & RdEn), 32'd0);
            check("ready_vs_busy", 32'(bus.busy & bus.cmd_ready), 32'd0);
        end
    end

    task automatic issue(input logic [1:0] op, input logic [3:0] addr,
                         input logic [3:0] len, input logic [15:0] data);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        bus.cmd_data  = data;
        @(negedge CLK);
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_addr [4];
        int         beats;
        int         t;

        RST = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.cmd_data  = '0;
        repeat (3) @(negedge CLK);

        // Reset state
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_wren", 32'(WrEn), 32'd0);
        check("rst_rden", 32'(RdEn), 32'd0);
        check("rst_address", 32'(Address), 32'd0);
        check("rst_wrdata", 32'(WrData), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        RST = 1'b0;
        mon_en = 1'b1;
        @(negedge CLK);

        // 1: WRITE addr 6 data 15, then READ addr 6
        issue(2'b00, 4'd6, 4'd0, 16'd15);
        check("t1_wren", 32'(WrEn), 32'd1);
        check("t1_address", 32'(Address), 32'd6);
        check("t1_wrdata", 32'(WrData), 32'd15);
        check("t1_busy", 32'(bus.busy), 32'd1);
        @(negedge CLK);
        check("t1_wren_off", 32'(WrEn), 32'd0);
        check("t1_ready_back", 32'(bus.cmd_ready), 32'd1);
        check("t1_addr_hold", 32'(Address), 32'd6);
        issue(2'b01, 4'd6, 4'd0, 16'd0);
        check("t1_rden", 32'(RdEn), 32'd1);
        check("t1_rd_address", 32'(Address), 32'd6);
        check("t1_rsp_early", 32'(bus.rsp_valid), 32'd0);
        @(negedge CLK);
        check("t1_rden_off", 32'(RdEn), 32'd0);
        check("t1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("t1_rsp_data", 32'(bus.rsp_data), 32'd15);
        check("t1_rsp_addr", 32'(bus.rsp_addr), 32'd6);
        @(negedge CLK);
        check("t1_rsp_pulse", 32'(bus.rsp_valid), 32'd0);
        check("t1_busy_off", 32'(bus.busy), 32'd0);

        // 2: FILL addr 6 len 3, then DUMP addr 6 len 3 (wraps 7 -> 0)
        exp_addr[0] = 4'd6; exp_addr[1] = 4'd7; exp_addr[2] = 4'd0; exp_addr[3] = 4'd1;
        issue(2'b10, 4'd6, 4'd3, 16'hA5A5);
        for (int i = 0; i < 5; i++) begin
            check("t2_fill_wren", 32'(WrEn), (i < 4) ? 32'd1 : 32'd0);
            if (i < 4) begin
                check("t2_fill_addr", 32'(Address), 32'(exp_addr[i]));
                check("t2_fill_data", 32'(WrData), 32'hA5A5);
            end
            @(negedge CLK);
        end
        issue(2'b11, 4'd6, 4'd3, 16'd0);
        for (int i = 0; i < 6; i++) begin
            check("t2_dump_rden", 32'(RdEn), (i < 4) ? 32'd1 : 32'd0);
            if (i < 4) check("t2_dump_addr", 32'(Address), 32'(exp_addr[i]));
            check("t2_rsp_valid", 32'(bus.rsp_valid), (i >= 1 && i <= 4) ? 32'd1 : 32'd0);
            if (i >= 1 && i <= 4) begin
                check("t2_rsp_data", 32'(bus.rsp_data), 32'hA5A5);
                check("t2_rsp_addr", 32'(bus.rsp_addr), 32'(exp_addr[i-1]));
            end
            check("t2_busy", 32'(bus.busy), (i < 5) ? 32'd1 : 32'd0);
            @(negedge CLK);
        end

        // 3: back-to-back commands with cmd_valid held high; monitor checks exclusivity
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            bus.cmd_op   = 2'($urandom_range(0, 3));
            bus.cmd_addr = 4'($urandom_range(0, 9));
            bus.cmd_len  = 4'($urandom_range(0, 3));
            bus.cmd_data = 16'($urandom);
            @(negedge CLK);
        end
        bus.cmd_valid = 1'b0;
        t = 0;
        while (bus.busy && t < 40) begin
            @(negedge CLK);
            t++;
        end
        check("t3_drained", 32'(bus.busy), 32'd0);
        @(negedge CLK);

        // 4: READ addr 9 rejected
        issue(2'b01, 4'd9, 4'd0, 16'd0);
        check("t4_err", 32'(bus.err), 32'd1);
        check("t4_no_rden", 32'(RdEn), 32'd0);
        check("t4_no_wren", 32'(WrEn), 32'd0);
        check("t4_ready", 32'(bus.cmd_ready), 32'd1);
        check("t4_busy", 32'(bus.busy), 32'd0);
        @(negedge CLK);
        check("t4_err_pulse", 32'(bus.err), 32'd0);
        check("t4_no_rden2", 32'(RdEn), 32'd0);

        // 5: DUMP addr 0 len 7 with reset after the 3rd RdEn
        issue(2'b11, 4'd0, 4'd7, 16'd0);
        check("t5_rd0", 32'(Address), 32'd0);
        @(negedge CLK);
        check("t5_rd1", 32'(Address), 32'd1);
        @(negedge CLK);
        check("t5_rden3", 32'(RdEn), 32'd1);
        check("t5_rd2", 32'(Address), 32'd2);
        RST = 1'b1;
        #1;
        check("t5_rst_rden", 32'(RdEn), 32'd0);
        check("t5_rst_address", 32'(Address), 32'd0);
        check("t5_rst_busy", 32'(bus.busy), 32'd0);
        check("t5_rst_ready", 32'(bus.cmd_ready), 32'd1);
        check("t5_rst_rsp", 32'(bus.rsp_valid), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            check("t5_no_rsp", 32'(bus.rsp_valid), 32'd0);
            check("t5_no_rden", 32'(RdEn), 32'd0);
        end
        issue(2'b00, 4'd3, 4'd0, 16'h1234);
        check("t5_wr_wren", 32'(WrEn), 32'd1);
        check("t5_wr_addr", 32'(Address), 32'd3);
        check("t5_wr_data", 32'(WrData), 32'h1234);
        @(negedge CLK);
        issue(2'b01, 4'd3, 4'd0, 16'd0);
        @(negedge CLK);
        check("t5_rd_rsp", 32'(bus.rsp_valid), 32'd1);
        check("t5_rd_data", 32'(bus.rsp_data), 32'h1234);
        @(negedge CLK);

        // 6: FILL all entries, then DUMP addr 2 len 15 (16 beats, revisits entries)
        issue(2'b10, 4'd0, 4'd7, 16'h5A5A);
        repeat (8) @(negedge CLK);
        check("t6_fill_done", 32'(bus.busy), 32'd0);
        issue(2'b11, 4'd2, 4'd15, 16'd0);
        beats = 0;
        for (int i = 0; i < 18; i++) begin
            check("t6_rden", 32'(RdEn), (i < 16) ? 32'd1 : 32'd0);
            if (i < 16) check("t6_issue_addr", 32'(Address), 32'((2 + i) % 8));
            check("t6_rsp_valid", 32'(bus.rsp_valid), (i >= 1 && i <= 16) ? 32'd1 : 32'd0);
            if (bus.rsp_valid) begin
                beats++;
                check("t6_rsp_data", 32'(bus.rsp_data), 32'h5A5A);
                check("t6_rsp_addr", 32'(bus.rsp_addr), 32'((1 + i) % 8));
            end
            check("t6_busy", 32'(bus.busy), (i <= 16) ? 32'd1 : 32'd0);
            @(negedge CLK);
        end
        check("t6_beat_count", 32'(beats), 32'd16);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
